// File: rtl/demux1_16_8b_reg.sv
// Registered 1-to-16 lane distributor with a valid/ready input, per-lane full flags and an auto pointer.
// Optional DEMUX_OVERWRITE_EN: in_ready is held at 1, writes to full lanes overwrite and set a sticky overflow.
module demux1_16_8b_reg #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sel3,
  input  logic             sel2,
  input  logic             sel1,
  input  logic             sel0,
  input  logic             auto_mode,
  input  logic             ptr_clr,
  input  logic [15:0]      ack,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [WIDTH-1:0] out4,
  output logic [WIDTH-1:0] out5,
  output logic [WIDTH-1:0] out6,
  output logic [WIDTH-1:0] out7,
  output logic [WIDTH-1:0] out8,
  output logic [WIDTH-1:0] out9,
  output logic [WIDTH-1:0] out10,
  output logic [WIDTH-1:0] out11,
  output logic [WIDTH-1:0] out12,
  output logic [WIDTH-1:0] out13,
  output logic [WIDTH-1:0] out14,
  output logic [WIDTH-1:0] out15,
  output logic [15:0]      full,
  output logic [15:0]      strobe,
  output logic [3:0]       ptr,
  output logic             frame_done,
  output logic             overflow
);

  logic [WIDTH-1:0] lane_q [16];
  logic [3:0]       lane;
  logic [15:0]      lane_oh;
  logic             accept;

  assign lane    = auto_mode ? ptr : {sel3, sel2, sel1, sel0};
  assign lane_oh = 16'b1 << lane;

`ifdef DEMUX_OVERWRITE_EN
  assign in_ready = 1'b1;
`else
  assign in_ready = ~full[lane];
`endif

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) lane_q[i] <= RESET_VAL;
    end else if (accept) begin
      lane_q[lane] <= in_data;
    end
  end

  // A write on the same lane as an ack wins: the ack refers to the previous byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full   <= '0;
      strobe <= '0;
    end else begin
      full   <= (full & ~ack) | (accept ? lane_oh : 16'h0000);
      strobe <= accept ? lane_oh : 16'h0000;
    end
  end

  // Clear beats increment; a clear is not a wrap, so it never raises frame_done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr        <= 4'd0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= accept & auto_mode & ~ptr_clr & (ptr == 4'd15);
      if (ptr_clr)
        ptr <= 4'd0;
      else if (accept && auto_mode)
        ptr <= ptr + 4'd1;
    end
  end

`ifdef DEMUX_OVERWRITE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      overflow <= 1'b0;
    else if (accept && full[lane])
      overflow <= 1'b1;
  end
`else
  assign overflow = 1'b0;
`endif

  assign out0  = lane_q[0];
  assign out1  = lane_q[1];
  assign out2  = lane_q[2];
  assign out3  = lane_q[3];
  assign out4  = lane_q[4];
  assign out5  = lane_q[5];
  assign out6  = lane_q[6];
  assign out7  = lane_q[7];
  assign out8  = lane_q[8];
  assign out9  = lane_q[9];
  assign out10 = lane_q[10];
  assign out11 = lane_q[11];
  assign out12 = lane_q[12];
  assign out13 = lane_q[13];
  assign out14 = lane_q[14];
  assign out15 = lane_q[15];

endmodule

// File: tb/tb_demux1_16_8b_reg.sv
// Bench for demux1_16_8b_reg: directed scenarios plus random traffic, checked every cycle against a lane-array model.
module tb_demux1_16_8b_reg;
  localparam logic [7:0] RV = 8'h5A;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  sel = '0;
  logic        auto_mode = 1'b0;
  logic        ptr_clr = 1'b0;
  logic [15:0] ack = '0;
  logic [7:0]  dut_out [16];
  logic [15:0] full, strobe;
  logic [3:0]  ptr;
  logic        frame_done, overflow;

  int n_checks = 0;
  int n_fail = 0;
  int fd_count;

  always #5 clk = ~clk;

  demux1_16_8b_reg #(.WIDTH(8), .RESET_VAL(RV)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .sel3(sel[3]), .sel2(sel[2]), .sel1(sel[1]), .sel0(sel[0]),
    .auto_mode(auto_mode), .ptr_clr(ptr_clr), .ack(ack),
    .out0(dut_out[0]), .out1(dut_out[1]), .out2(dut_out[2]), .out3(dut_out[3]),
    .out4(dut_out[4]), .out5(dut_out[5]), .out6(dut_out[6]), .out7(dut_out[7]),
    .out8(dut_out[8]), .out9(dut_out[9]), .out10(dut_out[10]), .out11(dut_out[11]),
    .out12(dut_out[12]), .out13(dut_out[13]), .out14(dut_out[14]), .out15(dut_out[15]),
    .full(full), .strobe(strobe), .ptr(ptr), .frame_done(frame_done), .overflow(overflow)
  );

  // Reference model: an array of 16 lanes, a full bitmap and a modulo-16 pointer.
  logic [7:0]  m_out [16];
  logic [15:0] m_full, m_strobe;
  int          m_ptr;
  logic        m_fd, m_ovf;
  int          m_lane;
  logic        m_ready, m_acc;

  assign m_lane  = auto_mode ? m_ptr : int'(sel);
`ifdef DEMUX_OVERWRITE_EN
  assign m_ready = 1'b1;
`else
  assign m_ready = !m_full[m_lane];
`endif
  assign m_acc   = in_valid && m_ready;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) m_out[i] <= RV;
      m_full <= '0; m_strobe <= '0; m_ptr <= 0; m_fd <= 1'b0; m_ovf <= 1'b0;
    end else begin
      if (m_acc) m_out[m_lane] <= in_data;
      m_full   <= (m_full & ~ack) | (m_acc ? (16'h0001 << m_lane) : 16'h0000);
      m_strobe <= m_acc ? (16'h0001 << m_lane) : 16'h0000;
      m_fd     <= m_acc && auto_mode && !ptr_clr && m_ptr == 15;
      if (ptr_clr) m_ptr <= 0;
      else if (m_acc && auto_mode) m_ptr <= (m_ptr + 1) % 16;
`ifdef DEMUX_OVERWRITE_EN
      if (m_acc && m_full[m_lane]) m_ovf <= 1'b1;
`endif
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 16; i++) check($sformatf("model out%0d", i), 32'(dut_out[i]), 32'(m_out[i]));
    check("model full", 32'(full), 32'(m_full));
    check("model strobe", 32'(strobe), 32'(m_strobe));
    check("model ptr", 32'(ptr), 32'(m_ptr));
    check("model frame_done", 32'(frame_done), 32'(m_fd));
    check("model overflow", 32'(overflow), 32'(m_ovf));
    check("model in_ready", 32'(in_ready), 32'(m_ready));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    step();
    check("reset out10", 32'(dut_out[10]), 32'(RV));
    check("reset full", 32'(full), 32'h0);
    check("reset ptr", 32'(ptr), 32'h0);

    // single explicit write to lane 10
    sel = 4'b1010; in_data = 8'hA5; in_valid = 1'b1;
    #1 check("ready lane10 empty", 32'(in_ready), 32'h1);
    step(); in_valid = 1'b0;
    check("out10 A5", 32'(dut_out[10]), 32'hA5);
    check("strobe lane10", 32'(strobe), 32'h0400);
    check("full lane10", 32'(full), 32'h0400);
    check("out9 untouched", 32'(dut_out[9]), 32'(RV));
    step();
    check("strobe one cycle", 32'(strobe), 32'h0);

`ifndef DEMUX_OVERWRITE_EN
    // stall on full lane, release by ack
    in_data = 8'h3C; in_valid = 1'b1;
    #1 check("ready stalled", 32'(in_ready), 32'h0);
    step();
    check("out10 held", 32'(dut_out[10]), 32'hA5);
    ack = 16'h0400;
    step(); ack = '0;
    #1 check("ready released", 32'(in_ready), 32'h1);
    step(); in_valid = 1'b0;
    check("out10 3C", 32'(dut_out[10]), 32'h3C);
`else
    in_data = 8'h3C; in_valid = 1'b1;
    step(); in_valid = 1'b0;
    check("overwrite out10", 32'(dut_out[10]), 32'h3C);
    check("overflow set", 32'(overflow), 32'h1);
`endif

    // auto frame of 16 writes with acks held high
    ack = 16'hFFFF; auto_mode = 1'b1; fd_count = 0;
    for (int i = 0; i < 16; i++) begin
      in_data = 8'(i); in_valid = 1'b1;
      step();
      if (frame_done) fd_count++;
      check("frame_done timing", 32'(frame_done), (i == 15) ? 32'h1 : 32'h0);
    end
    in_valid = 1'b0;
    check("frame_done count", 32'(fd_count), 32'h1);
    check("ptr wrapped", 32'(ptr), 32'h0);
    for (int i = 0; i < 16; i++) check($sformatf("frame out%0d", i), 32'(dut_out[i]), 32'(i));
    step(); ack = '0;

    // same-cycle ack and write on lane 3
    auto_mode = 1'b0; sel = 4'd3; in_data = 8'h22; in_valid = 1'b1; ack = 16'h0008;
    step(); in_valid = 1'b0; ack = '0;
    check("lane3 full kept", 32'(full[3]), 32'h1);
    check("out3 new", 32'(dut_out[3]), 32'h22);

    // ptr_clr coinciding with an accept at ptr 7
    ack = 16'hFFFF; auto_mode = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_data = 8'hE0 + 8'(i); in_valid = 1'b1; step();
    end
    check("ptr at 7", 32'(ptr), 32'h7);
    in_data = 8'h77; ptr_clr = 1'b1;
    step(); ptr_clr = 1'b0; in_valid = 1'b0;
    check("out7 77", 32'(dut_out[7]), 32'h77);
    check("ptr cleared", 32'(ptr), 32'h0);
    check("no frame_done on clear", 32'(frame_done), 32'h0);

    // asynchronous reset mid-stream at ptr 9
    for (int i = 0; i < 9; i++) begin
      in_data = 8'h90 + 8'(i); in_valid = 1'b1; step();
    end
    check("ptr at 9", 32'(ptr), 32'h9);
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    check("async out5", 32'(dut_out[5]), 32'(RV));
    check("async ptr", 32'(ptr), 32'h0);
    check("async full", 32'(full), 32'h0);
    check("async strobe", 32'(strobe), 32'h0);
    in_valid = 1'b0; ack = '0; auto_mode = 1'b0;
    @(negedge clk) rst_n = 1'b1;

    // random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      in_valid = ($urandom_range(0, 9) < 7);
      in_data  = 8'($urandom);
      if ($urandom_range(0, 19) == 0) auto_mode = ~auto_mode;
      if ($urandom_range(0, 3) == 0) sel = 4'($urandom);
      ptr_clr = ($urandom_range(0, 24) == 0);
      ack = ($urandom_range(0, 2) == 0) ? 16'($urandom) : 16'h0000;
    end
    in_valid = 1'b0;
    step();
    @(negedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/demux1_16_8b_reg.md
Name: demux1_16_8b_reg

Overview:
- Registered 1-to-16 byte distributor. It is the write-side counterpart of the 16:1 8-bit mux tree.
- Takes a byte stream with a valid/ready handshake and steers each byte into one of 16 held output registers.
- The lane is chosen by explicit select bits or by an internal auto-incrementing pointer.
- Per-lane full flags with consumer acknowledge give back-pressure. Used to load register banks that the mux tree later reads.

Parameters:
- WIDTH, 8, data width of input and of each output lane.
- RESET_VAL, 0, value loaded into every lane register at reset.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  WIDTH  byte to distribute.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block can accept in_data this cycle.
- sel3, sel2, sel1, sel0  input  1 each  explicit lane select; sel3 is the MSB.
- auto_mode  input  1  1 = lane comes from the internal pointer; 0 = lane comes from sel3..sel0.
- ptr_clr  input  1  synchronous clear of the auto pointer.
- ack  input  16  ack[i] = consumer has taken lane i; clears full[i].
- out0..out15  output  WIDTH each  held lane registers.
- full  output  16  full[i] = lane i holds unconsumed data.
- strobe  output  16  one-cycle pulse on the lane written in the previous cycle.
- ptr  output  4  current auto pointer value.
- frame_done  output  1  one-cycle pulse when the auto pointer wraps from 15 to 0.
- overflow  output  1  sticky flag; only when DEMUX_OVERWRITE_EN is defined, otherwise tied 0.

Behaviour:
- Reset (rst_n low, asynchronous):
  - out0..out15 = RESET_VAL.
  - full, strobe, ptr, frame_done, overflow = 0.
  - Any transfer in flight is discarded. The first accept is possible in the first cycle after rst_n rises.
- Lane selection (combinational): lane = auto_mode ? ptr : {sel3,sel2,sel1,sel0}.
- in_ready (combinational) = ~full[lane]. It does not depend on in_valid.
- Accept occurs on a rising edge with in_valid && in_ready. On accept:
  - out<lane> <= in_data.
  - full[lane] <= 1.
  - strobe <= one-hot(lane) in the next cycle, otherwise 0.
  - Write latency is 1 cycle: the data is visible on out<lane> the cycle after the accept.
- Non-selected lanes hold their value. Output registers change only on accept.
- Acknowledge: ack[i] clears full[i] at the next edge. Multiple ack bits may be set at once.
- Same-lane write and ack in the same cycle: the write wins; full stays 1 and the ack refers to the old data.
- ack on a lane that is already empty: ignored.
- Auto pointer:
  - Increments only on accept while auto_mode = 1.
  - Wraps 15 -> 0; an accept at ptr = 15 pulses frame_done for 1 cycle.
  - ptr_clr sets ptr to 0 and has priority over the increment; an accept in the same cycle writes to the old ptr lane.
  - The pointer holds its value while auto_mode = 0.
- Back-pressure: when full[lane] = 1, in_ready = 0. The upstream must hold in_data and in_valid stable. The stall clears the cycle after the matching ack.
- Changing sel or auto_mode while stalled re-evaluates in_ready combinationally. No hidden state is created.

Optional Feature:
- Macro: DEMUX_OVERWRITE_EN.
- When defined:
  - in_ready is tied to 1.
  - A write to a lane with full = 1 overwrites the data and still pulses strobe.
  - The overwrite sets overflow (sticky). overflow clears only on reset.
- When not defined: back-pressure behaviour as above, and overflow is tied 0.

Test Plan:
- Reset, then auto_mode = 0 with sel = 4'b1010 and in_data = 8'hA5 for 1 cycle -> out10 = A5 the next cycle, strobe = 16'h0400 for 1 cycle, full[10] = 1, all other outputs = RESET_VAL.
- Repeat the write to lane 10 with 8'h3C without ack -> in_ready = 0 and out10 stays A5. Pulse ack[10] -> the stall releases next cycle and out10 = 3C.
- auto_mode = 1, 16 consecutive accepts of 8'h00..8'h0F with all ack bits held high -> outN = N, ptr returns to 0, frame_done pulses once, coincident with the write of 0F being accepted.
- Same-lane ack and write in the same cycle on lane 3 -> full[3] remains 1 and out3 takes the new byte.
- ptr_clr asserted together with an accept at ptr = 7 -> the byte lands in out7 and ptr = 0 next cycle, with no frame_done.
- rst_n pulled low mid-stream while ptr = 9 -> all outputs return to their reset values immediately (asynchronously). With DEMUX_OVERWRITE_EN defined, a double write to lane 2 sets overflow = 1.
